// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory: streaming load port, then a
// registered fetch port with stall hold and bad-address flagging.
module instr_mem_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter bit          BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              ready_o,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic              addr_err_o,
  output logic [CNT_W-1:0]  loaded_cnt_o
);

  localparam int unsigned CMP_W =
    (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              wr_en;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx_full;
  logic              misalign;
  logic              range_err;
  logic              fetch_err;
  logic [DATA_W-1:0] mem_rd;

  // Index keeps the full address width so huge addresses never alias.
  always_comb begin
    idx_full  = BYTE_ADDR ? (fetch_addr_i >> 2) : fetch_addr_i;
    misalign  = BYTE_ADDR && (fetch_addr_i[1:0] != 2'b00);
    range_err = CMP_W'(idx_full) >= CMP_W'(cnt_q);
    fetch_err = misalign || range_err;
    mem_rd    = mem_q[idx_full[IDX_W-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    load_ready_o = 1'b0;
    ready_o      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        load_ready_o = 1'b1;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        if (load_en_i) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (load_last_i ||
              cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        ready_o = 1'b1;
        if (!stall_i) begin
          if (fetch_req_i) begin
            valid_d = 1'b1;
            err_d   = fetch_err;
            instr_d = fetch_err ? NOP_WORD : mem_rd;
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Reset outranks a concurrent load strobe.
  assign wr_en = mem_we & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[cnt_q[IDX_W-1:0]] <= load_data_i;
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign addr_err_o    = err_q;
  assign loaded_cnt_o  = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: word-index and byte-address instances
// driven from a vector table and hand sequences through a scoreboard.
module tb_instr_mem_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = $clog2(DEP) + 1;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          fetch_req;
  logic          stall;
  logic [AW-1:0] fa0, fa1;

  logic          lr0, rdy0, v0, e0;
  logic [DW-1:0] i0;
  logic [CW-1:0] c0;
  logic          lr1, rdy1, v1, e1;
  logic [DW-1:0] i1;
  logic [CW-1:0] c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
    .BYTE_ADDR(1'b0), .NOP_WORD(NOP)
  ) u_word (
    .clk_i(clk), .rst_i(rst),
    .load_en_i(load_en), .load_data_i(load_data),
    .load_last_i(load_last), .load_ready_o(lr0),
    .ready_o(rdy0), .fetch_req_i(fetch_req),
    .fetch_addr_i(fa0), .stall_i(stall),
    .instr_o(i0), .instr_valid_o(v0),
    .addr_err_o(e0), .loaded_cnt_o(c0)
  );

  instr_mem_loader #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
    .BYTE_ADDR(1'b1), .NOP_WORD(NOP)
  ) u_byte (
    .clk_i(clk), .rst_i(rst),
    .load_en_i(load_en), .load_data_i(load_data),
    .load_last_i(load_last), .load_ready_o(lr1),
    .ready_o(rdy1), .fetch_req_i(fetch_req),
    .fetch_addr_i(fa1), .stall_i(stall),
    .instr_o(i1), .instr_valid_o(v1),
    .addr_err_o(e1), .loaded_cnt_o(c1)
  );

  typedef struct {
    bit          sel;
    bit          req;
    bit          stl;
    logic [31:0] addr;
    logic [31:0] e_instr;
    bit          e_valid;
    bit          e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(bit sel, bit req, bit stl,
                              logic [31:0] addr,
                              logic [31:0] ei, bit ev, bit ee);
    vec_t v;
    v.sel = sel; v.req = req; v.stl = stl; v.addr = addr;
    v.e_instr = ei; v.e_valid = ev; v.e_err = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(string tag, vec_t v);
    vec_t e;
    fetch_req = v.req;
    stall     = v.stl;
    fa0 = v.sel ? 32'h0 : v.addr;
    fa1 = v.sel ? v.addr : 32'h0;
    sb.push_back(v);
    tick();
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      chk({tag, "_instr"}, i1, e.e_instr);
      chk({tag, "_valid"}, 32'(v1), 32'(e.e_valid));
      chk({tag, "_err"}, 32'(e1), 32'(e.e_err));
    end else begin
      chk({tag, "_instr"}, i0, e.e_instr);
      chk({tag, "_valid"}, 32'(v0), 32'(e.e_valid));
      chk({tag, "_err"}, 32'(e0), 32'(e.e_err));
    end
  endtask

  task automatic load_word(logic [31:0] d, bit last);
    load_en   = 1'b1;
    load_data = d;
    load_last = last;
    tick();
    load_en   = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  localparam logic [31:0] B = 32'h1000_0000;

  initial begin
    rst = 1'b0; load_en = 1'b0; load_data = '0;
    load_last = 1'b0; fetch_req = 1'b0; stall = 1'b0;
    fa0 = '0; fa1 = '0;

    // word-index instance (sel=0)
    vecs.push_back(mk(0, 1, 0, 5, B + 5, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, B + 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, B + 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, B + 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 3, B + 3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 7, B + 3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 7, B + 3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 7, B + 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 7, B + 7, 1, 0));
    vecs.push_back(mk(0, 1, 0, 10, NOP, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'hFFFF_FFFF, NOP, 1, 1));
    vecs.push_back(mk(0, 0, 0, 4, NOP, 0, 0));
    vecs.push_back(mk(0, 1, 0, 9, B + 9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, B + 9, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, B + 9, 0, 0));
    vecs.push_back(mk(0, 1, 1, 10, B + 9, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10, NOP, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, NOP, 1, 1));
    // byte-address instance (sel=1)
    vecs.push_back(mk(1, 1, 0, 32'h8, B + 2, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h6, NOP, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h24, B + 9, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h28, NOP, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h27, NOP, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0, B + 0, 1, 0));

    // reset, with load_en and stall asserted to show priority
    rst = 1'b1; load_en = 1'b1; stall = 1'b1;
    tick(); tick();
    rst = 1'b0; load_en = 1'b0; stall = 1'b0;
    chk("rst_cnt", 32'(c0), 32'd0);
    chk("rst_load_ready", 32'(lr0), 32'd1);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_instr", i0, NOP);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_err", 32'(e0), 32'd0);

    // load 10 words; fetch on the final write cycle must be ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        fetch_req = 1'b1;
        fa0 = 32'd5;
      end
      load_word(B + 32'(i), i == 9);
      if (i == 8) chk("ld_not_ready", 32'(rdy0), 32'd0);
    end
    fetch_req = 1'b0;
    chk("ld_ready", 32'(rdy0), 32'd1);
    chk("ld_load_ready", 32'(lr0), 32'd0);
    chk("ld_cnt", 32'(c0), 32'd10);
    chk("ld_trans_valid", 32'(v0), 32'd0);
    chk("ld_cnt_b", 32'(c1), 32'd10);

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);
    fetch_req = 1'b0;

    // fill all entries without load_last: auto transition
    do_reset();
    chk("fill_rst_cnt", 32'(c0), 32'd0);
    for (int i = 0; i < DEP; i++) begin
      load_word(32'hA000_0000 + 32'(i), 1'b0);
      if (i == DEP - 2) chk("fill_not_ready", 32'(rdy0), 32'd0);
    end
    chk("fill_ready", 32'(rdy0), 32'd1);
    chk("fill_cnt", 32'(c0), 32'(DEP));
    load_word(32'hDEAD_BEEF, 1'b1);
    chk("fill_cnt_hold", 32'(c0), 32'(DEP));
    apply("fill_m0", mk(0, 1, 0, 0, 32'hA000_0000, 1, 0));
    apply("fill_mtop", mk(0, 1, 0, DEP - 1,
                          32'hA000_0000 + 32'(DEP - 1), 1, 0));
    apply("fill_over", mk(0, 1, 0, DEP, NOP, 1, 1));
    fetch_req = 1'b0;

    // reset in the middle of a load, then a short reload
    do_reset();
    for (int i = 0; i < 4; i++)
      load_word(32'hC000_0000 + 32'(i), 1'b0);
    chk("mid_cnt4", 32'(c0), 32'd4);
    do_reset();
    chk("mid_rst_cnt", 32'(c0), 32'd0);
    chk("mid_rst_ready", 32'(rdy0), 32'd0);
    chk("mid_rst_lr", 32'(lr0), 32'd1);
    load_word(32'hB000_0000, 1'b0);
    load_word(32'hB000_0001, 1'b1);
    chk("re_cnt", 32'(c0), 32'd2);
    chk("re_ready", 32'(rdy0), 32'd1);
    apply("re_a3", mk(0, 1, 0, 3, NOP, 1, 1));
    apply("re_a2", mk(0, 1, 0, 2, NOP, 1, 1));
    apply("re_a1", mk(0, 1, 0, 1, 32'hB000_0001, 1, 0));
    apply("re_a0", mk(0, 1, 0, 0, 32'hB000_0000, 1, 0));
    apply("re_idle", mk(0, 0, 0, 0, 32'hB000_0000, 0, 0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
